sisc_mem_arb: RTL and testbench
===============================

Name: sisc_mem_arb

Overview:
- Arbiter and sequencer for a single shared memory port in the SISC datapath.
- Two requesters share the port: instruction fetch (IF, driven by pc/ir sequencing) and load/store (LS, driven by ctrl for memory-format instructions).
- Grants one access at a time, drives the memory control signals, waits a fixed latency, then returns read data with a one-cycle valid pulse to the granted requester.

Parameters:
- ADDR_W, 16, address width; matches the pc_out width.
- DATA_W, 32, data width; matches the instruction/register width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range is 1 or more.
- STARVE_MAX, 4, consecutive LS grants allowed while IF waits; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_f  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address; sampled in the if_gnt cycle.
- if_gnt  out  1  fetch granted; one-cycle pulse.
- if_valid  out  1  fetch data ready; one-cycle pulse.
- if_rdata  out  DATA_W  fetched word; holds until the next IF read.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_we  in  1  1 = store, 0 = load; sampled in the ls_gnt cycle.
- ls_addr  in  ADDR_W  load/store address; sampled in the ls_gnt cycle.
- ls_wdata  in  DATA_W  store data; sampled in the ls_gnt cycle.
- ls_gnt  out  1  LS granted; one-cycle pulse.
- ls_valid  out  1  load data ready or store acknowledged; one-cycle pulse.
- ls_rdata  out  DATA_W  loaded word; holds until the next LS load.
- mem_en  out  1  memory access strobe; one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset: on rst_f=1, immediately and asynchronously:
  - state becomes IDLE;
  - all outputs are 0, including if_rdata and ls_rdata;
  - the latency counter and starvation counter are 0.
- Reset mid-operation: an in-flight access is abandoned, and no valid pulse is produced for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - if_gnt and ls_gnt are combinational in this state only.
  - If ls_req=1, ls_gnt=1; otherwise if if_req=1, if_gnt=1.
  - If both requesters are present, LS wins unless the optional feature overrides.
  - On a grant, latch the owner, address, we and wdata, then go to ISSUE.
  - If neither requester is present, stay in IDLE.
- ISSUE (one cycle):
  - mem_en=1; mem_we = latched we; mem_addr and mem_wdata = latched values.
  - Load the counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_en=0; mem_addr stays held.
  - Decrement the counter each cycle.
  - When the counter is 0: for a read, capture mem_rdata into the owner's rdata register; then go to RESP.
- RESP (one cycle):
  - Owner's valid=1; rdata is stable in this cycle.
  - Stores pulse ls_valid and leave ls_rdata unchanged.
  - Go to IDLE; a new grant may occur in the following cycle.
- Timing with MEM_LAT=2:
  - gnt at cycle 0, mem_en at cycle 1, rdata captured at the edge ending cycle 3, valid at cycle 4.
  - One access per MEM_LAT+3 cycles.
- Requests:
  - Requests arriving outside IDLE receive no grant; the requester keeps req high.
  - Dropping req before gnt is legal and produces no access.
- IF writes: the IF side never writes; the latched we for an IF grant is forced to 0.
- Simultaneous valid: at most one of if_valid/ls_valid is high in any cycle.
- Address width: addresses pass through unmodified, with no wrap or alignment logic.

Optional Feature:
- Macro: SISC_ARB_FAIR_EN.
- Without the macro:
  - strict LS priority; IF can starve indefinitely;
  - the STARVE_MAX parameter and the starvation counter are absent.
- With the macro, a 3-bit-or-wider starvation counter:
  - increments on each LS grant while if_req=1;
  - clears on any IF grant, or in any IDLE cycle where if_req=0.
  - When the counter equals STARVE_MAX and both requesters are present, IF is granted.

Test Plan:
- Single load: ls_req=1, ls_we=0, ls_addr=0x0010, memory returns 0xDEADBEEF (MEM_LAT=2) -> ls_gnt at c0, mem_en/mem_addr=0x0010 at c1, ls_valid with ls_rdata=0xDEADBEEF at c4, busy c1-c4.
- Store: ls_we=1, ls_addr=0x0004, ls_wdata=0x12345678 -> mem_en=mem_we=1 at c1 with that address and data; ls_valid at c4; ls_rdata unchanged.
- Contention: if_req and ls_req both high continuously, no macro -> only ls_gnt pulses, every 5 cycles; if_gnt never asserts.
- Fairness (SISC_ARB_FAIR_EN, STARVE_MAX=4): both requesters held high -> grant order LS, LS, LS, LS, IF, LS, ...; if_valid returns if_rdata = word at if_addr.
- Reset mid-access: assert rst_f during WAIT -> outputs 0 immediately; no valid pulse; after release, if_req=1 gets if_gnt in the first cycle.
- MEM_LAT=1 build: single fetch at 0x0000 -> gnt c0, mem_en c1, if_valid c3.

Source files
------------

// File: rtl/sisc_mem_arb_if.sv
// Requester-side and memory-side signals of the shared SISC memory port.
// The arbiter connects through the slave modport; the environment uses master.
interface sisc_mem_arb_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_gnt;
   logic              ls_valid;
   logic [DATA_W-1:0] ls_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/sisc_mem_arb.sv
// Arbiter/sequencer for the single shared SISC memory port (fetch vs load/store).
// Optional fairness (bounded IF starvation) is enabled by defining SISC_ARB_FAIR_EN.
module sisc_mem_arb #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
`ifdef SISC_ARB_FAIR_EN
   ,
   parameter int STARVE_MAX = 4
`endif
) (
   input logic           clk,
   input logic           rst_f,
   sisc_mem_arb_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  lat_cnt;
   logic              own_ls;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] ls_rdata_q;

   logic              idle_ok;
   logic              ls_pick;
   logic              grant_ls;
   logic              grant_if;

   // Grants are only offered from IDLE and are forced low while reset is held.
   assign idle_ok = (state == ST_IDLE) && !rst_f;

`ifdef SISC_ARB_FAIR_EN
   localparam int SC_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

   logic [SC_W-1:0] starve_cnt;
   logic            starve_hit;

   assign starve_hit = (starve_cnt == SC_W'(STARVE_MAX));

   always_comb begin
      ls_pick = bus.ls_req;
      if (bus.if_req && starve_hit) ls_pick = 1'b0;
   end

   // Counts back-to-back LS wins while IF is waiting; any IF grant or an IDLE
   // cycle without a fetch request forgives the debt.
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         starve_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (grant_if || !bus.if_req) starve_cnt <= '0;
         else if (grant_ls)           starve_cnt <= starve_cnt + SC_W'(1);
      end
   end
`else
   always_comb begin
      ls_pick = bus.ls_req;
   end
`endif

   assign grant_ls = idle_ok && ls_pick;
   assign grant_if = idle_ok && !ls_pick && bus.if_req;

   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_ls || grant_if) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request capture, latency countdown and read-data capture for the owner.
   always_ff @(posedge clk or posedge rst_f) begin
      if (rst_f) begin
         lat_cnt    <= '0;
         own_ls     <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_ls) begin
                  own_ls    <= 1'b1;
                  lat_we    <= bus.ls_we;
                  lat_addr  <= bus.ls_addr;
                  lat_wdata <= bus.ls_wdata;
               end else if (grant_if) begin
                  own_ls    <= 1'b0;
                  lat_we    <= 1'b0;
                  lat_addr  <= bus.if_addr;
                  lat_wdata <= '0;
               end
            end
            ST_ISSUE: begin
               lat_cnt <= CNT_LOAD;
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  if (!lat_we) begin
                     if (own_ls) ls_rdata_q <= bus.mem_rdata;
                     else        if_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.if_gnt    = grant_if;
   assign bus.ls_gnt    = grant_ls;
   assign bus.if_valid  = (state == ST_RESP) && !own_ls;
   assign bus.ls_valid  = (state == ST_RESP) && own_ls;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.mem_en    = (state == ST_ISSUE);
   assign bus.mem_we    = (state == ST_ISSUE) && lat_we;
   assign bus.mem_addr  = lat_addr;
   assign bus.mem_wdata = lat_wdata;
   assign bus.busy      = (state != ST_IDLE);

`ifndef SYNTHESIS
   a_valid_excl: assert property (@(posedge clk) disable iff (rst_f)
      !(bus.if_valid && bus.ls_valid));
   a_gnt_excl: assert property (@(posedge clk) disable iff (rst_f)
      !(bus.if_gnt && bus.ls_gnt));
`endif

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Directed bench for sisc_mem_arb: vector table of single accesses plus
// hand-written contention, late-request and mid-access reset sequences.
module tb_sisc_mem_arb;

   logic clk = 1'b0;
   logic rst_f;

   sisc_mem_arb_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   sisc_mem_arb #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory with a two-stage read pipe: data is valid two cycles after mem_en.
   logic [31:0] mem_arr [256];
   logic        mem_loaded = 1'b0;
   logic [31:0] rd_pipe0 = 32'h0;
   logic [31:0] rd_pipe1 = 32'h0;

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
         mem_arr[8'h00] <= 32'hA5A5_0001;
         mem_arr[8'h10] <= 32'hDEAD_BEEF;
         mem_arr[8'h20] <= 32'h0BAD_C0DE;
         mem_arr[8'hFF] <= 32'hCAFE_F00D;
         mem_loaded     <= 1'b1;
      end else if (bus.mem_en && bus.mem_we) begin
         mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      end
      rd_pipe0 <= bus.mem_en ? mem_arr[bus.mem_addr[7:0]] : 32'h0;
      rd_pipe1 <= rd_pipe0;
   end

   assign bus.mem_rdata = rd_pipe1;

   typedef struct packed {
      logic        is_ls;
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output(name, {31'b0, bus.busy}, 32'h0);
   endtask

   task automatic apply_stimulus(input int idx, input vec_t v);
      int n = 0;
      step();
      if (v.is_ls) begin
         bus.ls_req   = 1'b1;
         bus.ls_we    = v.we;
         bus.ls_addr  = v.addr;
         bus.ls_wdata = v.wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = v.addr;
      end
      @(negedge clk);
      while (!(v.is_ls ? bus.ls_gnt : bus.if_gnt) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_output($sformatf("vec%0d gnt", idx), {31'b0, v.is_ls ? bus.ls_gnt : bus.if_gnt}, 32'h1);
      check_output($sformatf("vec%0d gnt_cycle", idx), n, 0);

      step();
      bus.ls_req = 1'b0;
      bus.if_req = 1'b0;
      @(negedge clk);
      check_output($sformatf("vec%0d c1 mem_en", idx), {31'b0, bus.mem_en}, 32'h1);
      check_output($sformatf("vec%0d c1 mem_we", idx), {31'b0, bus.mem_we}, {31'b0, v.we});
      check_output($sformatf("vec%0d c1 mem_addr", idx), {16'b0, bus.mem_addr}, {16'b0, v.addr});
      if (v.we) check_output($sformatf("vec%0d c1 mem_wdata", idx), bus.mem_wdata, v.wdata);
      check_output($sformatf("vec%0d c1 busy", idx), {31'b0, bus.busy}, 32'h1);

      @(negedge clk);
      check_output($sformatf("vec%0d c2 mem_en", idx), {31'b0, bus.mem_en}, 32'h0);
      check_output($sformatf("vec%0d c2 mem_addr", idx), {16'b0, bus.mem_addr}, {16'b0, v.addr});
      @(negedge clk);
      check_output($sformatf("vec%0d c3 valid", idx), {30'b0, bus.if_valid, bus.ls_valid}, 32'h0);
      @(negedge clk);
      if (v.is_ls) begin
         check_output($sformatf("vec%0d c4 ls_valid", idx), {31'b0, bus.ls_valid}, 32'h1);
         check_output($sformatf("vec%0d c4 if_valid", idx), {31'b0, bus.if_valid}, 32'h0);
         check_output($sformatf("vec%0d c4 ls_rdata", idx), bus.ls_rdata, v.exp_rdata);
      end else begin
         check_output($sformatf("vec%0d c4 if_valid", idx), {31'b0, bus.if_valid}, 32'h1);
         check_output($sformatf("vec%0d c4 ls_valid", idx), {31'b0, bus.ls_valid}, 32'h0);
         check_output($sformatf("vec%0d c4 if_rdata", idx), bus.if_rdata, v.exp_rdata);
      end
      check_output($sformatf("vec%0d c4 busy", idx), {31'b0, bus.busy}, 32'h1);
      @(negedge clk);
      check_output($sformatf("vec%0d c5 busy", idx), {31'b0, bus.busy}, 32'h0);
      check_output($sformatf("vec%0d c5 valid", idx), {30'b0, bus.if_valid, bus.ls_valid}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t vecs [8];
      int   n_ls;
      int   n_if;
      int   n_g;
      int   seen;
      int   n;

      vecs[0] = '{is_ls: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
      vecs[1] = '{is_ls: 1'b1, we: 1'b1, addr: 16'h0004, wdata: 32'h1234_5678, exp_rdata: 32'hDEAD_BEEF};
      vecs[2] = '{is_ls: 1'b1, we: 1'b0, addr: 16'h0004, wdata: 32'h0,         exp_rdata: 32'h1234_5678};
      vecs[3] = '{is_ls: 1'b0, we: 1'b0, addr: 16'h0000, wdata: 32'h0,         exp_rdata: 32'hA5A5_0001};
      vecs[4] = '{is_ls: 1'b0, we: 1'b0, addr: 16'hFFFF, wdata: 32'h0,         exp_rdata: 32'hCAFE_F00D};
      vecs[5] = '{is_ls: 1'b1, we: 1'b0, addr: 16'h0020, wdata: 32'h0,         exp_rdata: 32'h0BAD_C0DE};
      vecs[6] = '{is_ls: 1'b1, we: 1'b1, addr: 16'h0020, wdata: 32'hFFFF_FFFF, exp_rdata: 32'h0BAD_C0DE};
      vecs[7] = '{is_ls: 1'b0, we: 1'b0, addr: 16'h0020, wdata: 32'h0,         exp_rdata: 32'hFFFF_FFFF};

      rst_f        = 1'b1;
      bus.if_req   = 1'b1;
      bus.if_addr  = 16'h0000;
      bus.ls_req   = 1'b0;
      bus.ls_we    = 1'b0;
      bus.ls_addr  = 16'h0000;
      bus.ls_wdata = 32'h0;

      // Reset state, including a fetch request held during reset.
      repeat (3) @(negedge clk);
      check_output("rst if_gnt", {31'b0, bus.if_gnt}, 32'h0);
      check_output("rst busy", {31'b0, bus.busy}, 32'h0);
      check_output("rst mem_en", {30'b0, bus.mem_en, bus.mem_we}, 32'h0);
      check_output("rst mem_addr", {16'b0, bus.mem_addr}, 32'h0);
      check_output("rst valid", {30'b0, bus.if_valid, bus.ls_valid}, 32'h0);
      check_output("rst if_rdata", bus.if_rdata, 32'h0);
      check_output("rst ls_rdata", bus.ls_rdata, 32'h0);
      step();
      rst_f      = 1'b0;
      bus.if_req = 1'b0;

      for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

      // Fetch request raised mid-access gets no grant until IDLE; an LS request
      // dropped before IDLE produces no access.
      step();
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 16'h0010;
      @(negedge clk);
      check_output("late ls_gnt c0", {31'b0, bus.ls_gnt}, 32'h1);
      step();
      bus.ls_req  = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0000;
      @(negedge clk);
      seen = int'(bus.if_gnt);
      repeat (3) begin
         step();
         @(negedge clk);
         seen += int'(bus.if_gnt);
      end
      check_output("late if_gnt while busy", seen, 0);
      step();
      @(negedge clk);
      check_output("late if_gnt at idle", {31'b0, bus.if_gnt}, 32'h1);
      step();
      bus.if_req = 1'b0;
      @(negedge clk);
      step();
      bus.ls_req = 1'b1;
      @(negedge clk);
      check_output("late ls_gnt while busy", {31'b0, bus.ls_gnt}, 32'h0);
      step();
      bus.ls_req = 1'b0;
      @(negedge clk);
      step();
      @(negedge clk);
      check_output("late if_valid", {31'b0, bus.if_valid}, 32'h1);
      check_output("late if_rdata", bus.if_rdata, 32'hA5A5_0001);
      seen = 0;
      repeat (4) begin
         step();
         @(negedge clk);
         seen += int'(bus.mem_en) + int'(bus.ls_gnt) + int'(bus.busy);
      end
      check_output("dropped req no access", seen, 0);

      // Both requesters held high continuously.
      step();
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0000;
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 16'h0010;
      n_ls = 0;
      n_if = 0;
      n_g  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.if_gnt || bus.ls_gnt) begin
            check_output($sformatf("cont grant%0d cycle", n_g), i % 5, 0);
`ifdef SISC_ARB_FAIR_EN
            check_output($sformatf("cont grant%0d is_if", n_g), {31'b0, bus.if_gnt}, (n_g == 4) ? 32'h1 : 32'h0);
`endif
            n_g++;
         end
         n_ls += int'(bus.ls_gnt);
         n_if += int'(bus.if_gnt);
      end
      step();
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      @(negedge clk);
      wait_idle("cont return idle");
      check_output("cont grant count", n_g, 6);
`ifdef SISC_ARB_FAIR_EN
      check_output("cont if grants", n_if, 1);
      check_output("cont fair if_rdata", bus.if_rdata, 32'hA5A5_0001);
`else
      check_output("cont if grants", n_if, 0);
      check_output("cont ls grants", n_ls, 6);
`endif
      check_output("cont ls_rdata", bus.ls_rdata, 32'hDEAD_BEEF);

      // Reset asserted during WAIT abandons the access.
      step();
      bus.ls_req  = 1'b1;
      bus.ls_we   = 1'b0;
      bus.ls_addr = 16'h0020;
      @(negedge clk);
      check_output("rstmid ls_gnt", {31'b0, bus.ls_gnt}, 32'h1);
      step();
      bus.ls_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      seen = 0;
      #1 rst_f = 1'b1;
      #1;
      check_output("rstmid busy", {31'b0, bus.busy}, 32'h0);
      check_output("rstmid mem_addr", {16'b0, bus.mem_addr}, 32'h0);
      check_output("rstmid ls_rdata", bus.ls_rdata, 32'h0);
      check_output("rstmid if_rdata", bus.if_rdata, 32'h0);
      repeat (2) begin
         @(negedge clk);
         seen += int'(bus.ls_valid) + int'(bus.if_valid);
      end
      step();
      rst_f       = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0010;
      @(negedge clk);
      check_output("rstmid if_gnt first cycle", {31'b0, bus.if_gnt}, 32'h1);
      step();
      bus.if_req = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.if_valid && n < 10) begin
         seen += int'(bus.ls_valid);
         @(negedge clk);
         n++;
      end
      check_output("rstmid if_valid", {31'b0, bus.if_valid}, 32'h1);
      check_output("rstmid if_valid cycle", n, 3);
      check_output("rstmid if_rdata after", bus.if_rdata, 32'hDEAD_BEEF);
      check_output("rstmid no stale valid", seen, 0);
      check_output("rstmid ls_rdata after", bus.ls_rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
